// File: rtl/pulse_train_gen_if.sv
// ---------------------------------------------------------------------------
// pulse_train_gen_if
//   Groups the burst-request and status signals of pulse_train_gen.
//
//   Parameter
//     WIDTH      width of count / remaining
//
//   Signals
//     start      burst request, sampled on the rising clock edge
//     count      number of pulses to emit, sampled with start
//     abort      terminate the burst in progress
//     pulse      registered pulse-train output
//     busy       burst in progress
//     done       one-cycle completion strobe
//     remaining  pulses still to complete in the current burst
//
//   Modports
//     master     requester side (drives start/count/abort)
//     slave      generator side (drives pulse/busy/done/remaining)
// ---------------------------------------------------------------------------
interface pulse_train_gen_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] count;
  logic             abort;
  logic             pulse;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remaining;

  modport master (
    output start,
    output count,
    output abort,
    input  pulse,
    input  busy,
    input  done,
    input  remaining
  );

  modport slave (
    input  start,
    input  count,
    input  abort,
    output pulse,
    output busy,
    output done,
    output remaining
  );

endinterface

// File: rtl/pulse_train_gen.sv
// ---------------------------------------------------------------------------
// pulse_train_gen
//   Emits a burst of `count` pulses. Each pulse is HI_CYC cycles high followed
//   by LO_CYC cycles low. A one-cycle done strobe follows a completed burst;
//   abort or reset abandons a burst silently.
//
//   Parameters
//     WIDTH   width of count / remaining (must match the interface instance)
//     HI_CYC  cycles per high phase, 1..255
//     LO_CYC  cycles per low phase, 1..255
//
//   Ports
//     clk     single clock, rising edge
//     rst     asynchronous active-high reset
//     bus     pulse_train_gen_if.slave: start, count, abort in;
//             pulse, busy, done, remaining out
// ---------------------------------------------------------------------------
module pulse_train_gen #(
  parameter int WIDTH  = 4,
  parameter int HI_CYC = 1,
  parameter int LO_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  pulse_train_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Terminal values of the 8-bit phase timers; a phase lasts N cycles when
  // the timer runs 0 .. N-1 and the transition fires on the last count.
  localparam logic [7:0] HI_LAST = 8'(HI_CYC - 1);
  localparam logic [7:0] LO_LAST = 8'(LO_CYC - 1);

  state_t           state;
  logic [7:0]       hi_timer;
  logic [7:0]       lo_timer;
  logic [WIDTH-1:0] remaining_q;
  logic             pulse_q;
  logic             busy_q;
  logic             done_q;

  // Outputs come straight from registers, so there is no combinational path
  // from start/count/abort to any output.
  assign bus.pulse     = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = remaining_q;

  // State and all outputs are updated together on each transition so the
  // registered outputs always agree with the state they describe:
  //   pulse = (state == HIGH), busy = HIGH|LOW, done = (state == DONE).
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the value from before this clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hi_timer    <= 8'd0;
      lo_timer    <= 8'd0;
      remaining_q <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: done is a strobe; defaulting it low here means only the
      // transition into DONE raises it, and it drops on the next edge.
      done_q <= 1'b0;

      case (state)
        IDLE: begin
          // abort has priority over a simultaneous start.
          if (bus.start && !bus.abort) begin
            if (bus.count != '0) begin
              state       <= HIGH;
              hi_timer    <= 8'd0;
              remaining_q <= bus.count;
              pulse_q     <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              // Empty burst: complete immediately without a pulse.
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end

        HIGH: begin
          if (bus.abort) begin
            state       <= IDLE;
            hi_timer    <= 8'd0;
            lo_timer    <= 8'd0;
            remaining_q <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
          end else if (hi_timer == HI_LAST) begin
            // A pulse counts as completed when its high phase ends.
            state    <= LOW;
            hi_timer <= 8'd0;
            lo_timer <= 8'd0;
            pulse_q  <= 1'b0;
            if (remaining_q != '0) begin
              remaining_q <= remaining_q - 1'b1;
            end
          end else begin
            hi_timer <= hi_timer + 8'd1;
          end
        end

        LOW: begin
          if (bus.abort) begin
            state       <= IDLE;
            hi_timer    <= 8'd0;
            lo_timer    <= 8'd0;
            remaining_q <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
          end else if (lo_timer == LO_LAST) begin
            lo_timer <= 8'd0;
            if (remaining_q == '0) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state    <= HIGH;
              hi_timer <= 8'd0;
              pulse_q  <= 1'b1;
            end
          end else begin
            lo_timer <= lo_timer + 8'd1;
          end
        end

        DONE: begin
          // Exactly one cycle here; start is ignored until back in IDLE.
          state <= IDLE;
        end

        default: begin
          state       <= IDLE;
          hi_timer    <= 8'd0;
          lo_timer    <= 8'd0;
          remaining_q <= '0;
          pulse_q     <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_train_gen
//   Directed self-checking bench for pulse_train_gen. Instance a uses the
//   default timing (HI_CYC=1, LO_CYC=1); instance b uses HI_CYC=2, LO_CYC=3.
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_pulse_train_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pulse_train_gen_if #(.WIDTH(4)) a_if ();
  pulse_train_gen_if #(.WIDTH(4)) b_if ();

  pulse_train_gen #(.WIDTH(4), .HI_CYC(1), .LO_CYC(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  pulse_train_gen #(.WIDTH(4), .HI_CYC(2), .LO_CYC(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic p, input logic b,
                         input logic d, input logic [3:0] r);
    check({tag, "_pulse"},     32'(a_if.pulse),     32'(p));
    check({tag, "_busy"},      32'(a_if.busy),      32'(b));
    check({tag, "_done"},      32'(a_if.done),      32'(d));
    check({tag, "_remaining"}, 32'(a_if.remaining), 32'(r));
  endtask

  initial begin
    logic [9:0] b_pattern;
    int         pulses;
    int         busy_cycles;
    int         cycles;
    bit         seen_done;
    logic [3:0] prev_rem;

    a_if.start = 1'b0; a_if.count = 4'd0; a_if.abort = 1'b0;
    b_if.start = 1'b0; b_if.count = 4'd0; b_if.abort = 1'b0;

    // ---- Reset state, before any clock edge ----
    #3;
    check_a("reset", 1'b0, 1'b0, 1'b0, 4'd0);
    check("reset_b_busy", 32'(b_if.busy), 32'd0);
    step();
    step();
    rst = 1'b0;

    // ---- count=3, defaults: pulse 1,0,1,0,1,0; remaining 3,2,2,1,1,0 ----
    a_if.start = 1'b1; a_if.count = 4'd3;
    step();
    a_if.start = 1'b0; a_if.count = 4'd0;
    for (int i = 0; i < 6; i++) begin
      check_a($sformatf("c3_cyc%0d", i + 1), (i % 2) == 0, 1'b1, 1'b0,
              4'(3 - (i + 1) / 2));
      step();
    end
    check_a("c3_done", 1'b0, 1'b0, 1'b1, 4'd0);
    step();
    check_a("c3_idle", 1'b0, 1'b0, 1'b0, 4'd0);

    // ---- HI_CYC=2, LO_CYC=3, count=2 on instance b ----
    b_pattern = 10'b1100011000;
    b_if.start = 1'b1; b_if.count = 4'd2;
    step();
    b_if.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("b_pulse%0d", i + 1), 32'(b_if.pulse), 32'(b_pattern[9 - i]));
      check($sformatf("b_busy%0d", i + 1),  32'(b_if.busy),  32'd1);
      step();
    end
    check("b_done",      32'(b_if.done), 32'd1);
    check("b_done_busy", 32'(b_if.busy), 32'd0);
    step();
    check("b_done_off",  32'(b_if.done), 32'd0);

    // ---- count=0: no pulse, done next cycle ----
    a_if.start = 1'b1; a_if.count = 4'd0;
    step();
    a_if.start = 1'b0;
    check_a("c0_done", 1'b0, 1'b0, 1'b1, 4'd0);
    step();
    check_a("c0_idle", 1'b0, 1'b0, 1'b0, 4'd0);

    // ---- abort and start together in IDLE: start discarded ----
    a_if.start = 1'b1; a_if.count = 4'd2; a_if.abort = 1'b1;
    step();
    a_if.start = 1'b0; a_if.abort = 1'b0;
    check_a("abort_vs_start", 1'b0, 1'b0, 1'b0, 4'd0);

    // ---- count=5, abort during 2nd HIGH phase ----
    a_if.start = 1'b1; a_if.count = 4'd5;
    step();
    a_if.start = 1'b0;
    check_a("ab_h1", 1'b1, 1'b1, 1'b0, 4'd5);
    step();
    check_a("ab_l1", 1'b0, 1'b1, 1'b0, 4'd4);
    step();
    check_a("ab_h2", 1'b1, 1'b1, 1'b0, 4'd4);
    a_if.abort = 1'b1;
    step();
    a_if.abort = 1'b0;
    check_a("ab_after", 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    check_a("ab_nodone", 1'b0, 1'b0, 1'b0, 4'd0);
    a_if.start = 1'b1; a_if.count = 4'd1;
    step();
    a_if.start = 1'b0;
    check_a("ab_c1_h", 1'b1, 1'b1, 1'b0, 4'd1);
    step();
    check_a("ab_c1_l", 1'b0, 1'b1, 1'b0, 4'd0);
    step();
    check_a("ab_c1_done", 1'b0, 1'b0, 1'b1, 4'd0);
    step();

    // ---- count=15, mid-burst start ignored, back-to-back restart ----
    a_if.start = 1'b1; a_if.count = 4'd15;
    step();
    a_if.start = 1'b0;
    pulses = 0; busy_cycles = 0; cycles = 0; seen_done = 1'b0;
    prev_rem = 4'd15;
    while (!seen_done && cycles < 100) begin
      if (cycles == 7)  begin a_if.start = 1'b1; a_if.count = 4'd3; end
      if (cycles == 8)  begin a_if.start = 1'b0; a_if.count = 4'd0; end
      if (a_if.pulse === 1'b1) pulses++;
      if (a_if.busy === 1'b1)  busy_cycles++;
      if (a_if.remaining > prev_rem) begin
        check("c15_rem_monotonic", 32'(a_if.remaining), 32'(prev_rem));
      end
      prev_rem = a_if.remaining;
      if (a_if.done === 1'b1) seen_done = 1'b1;
      else begin
        step();
        cycles++;
      end
    end
    check("c15_done_seen",   32'(seen_done), 32'd1);
    check("c15_pulses",      32'(pulses),      32'd15);
    check("c15_busy_cycles", 32'(busy_cycles), 32'd30);
    check("c15_rem_end",     32'(a_if.remaining), 32'd0);
    // start held through DONE; it is accepted in the following IDLE cycle.
    a_if.start = 1'b1; a_if.count = 4'd2;
    step();
    check_a("b2b_idle", 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    a_if.start = 1'b0; a_if.count = 4'd0;
    check_a("b2b_h1", 1'b1, 1'b1, 1'b0, 4'd2);
    for (int i = 0; i < 3; i++) step();
    check_a("b2b_l2", 1'b0, 1'b1, 1'b0, 4'd0);
    step();
    check_a("b2b_done", 1'b0, 1'b0, 1'b1, 4'd0);
    step();

    // ---- asynchronous reset mid-pulse ----
    a_if.start = 1'b1; a_if.count = 4'd3;
    step();
    a_if.start = 1'b0;
    check_a("rst_pre", 1'b1, 1'b1, 1'b0, 4'd3);
    #2;
    rst = 1'b1;
    #1;
    check_a("rst_async", 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    check_a("rst_held", 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    a_if.start = 1'b1; a_if.count = 4'd1;
    step();
    a_if.start = 1'b0;
    check_a("rst_first_start", 1'b1, 1'b1, 1'b0, 4'd1);
    step();
    step();
    check_a("rst_c1_done", 1'b0, 1'b0, 1'b1, 4'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
